// File: rtl/triangle_pwm.sv
// rtl/triangle_pwm.sv - triangle-envelope breathing LED PWM driver
module triangle_pwm #(
    parameter int N = 8,
    parameter int H = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic [N-1:0] duty_max,
    input  logic [H-1:0] hold_steps,
    output logic         pwm_out,
    output logic [N-1:0] duty,
    output logic [1:0]   phase,
    output logic         cycle_done
);

    typedef enum logic [1:0] {
        RISE      = 2'd0,
        HOLD_HIGH = 2'd1,
        FALL      = 2'd2,
        HOLD_LOW  = 2'd3
    } phase_t;

    phase_t       state, state_nxt;
    logic [N-1:0] duty_q, duty_nxt;
    logic [H-1:0] hold_cnt, hold_nxt;
    logic         done_nxt;
    logic [N-1:0] pwm_cnt;
    logic [N:0]   duty_inc;
    logic         accept;
    logic         hold_done;

    // duty+1 is formed one bit wider so duty_max = 2^N-1 never wraps
    assign accept    = step & ena;
    assign duty_inc  = {1'b0, duty_q} + (N+1)'(1);
    assign hold_done = (hold_cnt >= hold_steps);

    // Envelope state register; cycle_done is a registered one-clk pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RISE;
            duty_q     <= '0;
            hold_cnt   <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            duty_q     <= duty_nxt;
            hold_cnt   <= hold_nxt;
            cycle_done <= done_nxt;
        end
    end

    // Next envelope state; everything holds unless a step is accepted
    always_comb begin
        state_nxt = state;
        duty_nxt  = duty_q;
        hold_nxt  = hold_cnt;
        done_nxt  = 1'b0;
        if (accept) begin
            case (state)
                RISE: begin
                    // >= also clamps a duty left above a lowered duty_max
                    if (duty_inc >= {1'b0, duty_max}) begin
                        duty_nxt  = duty_max;
                        state_nxt = HOLD_HIGH;
                        hold_nxt  = '0;
                    end else begin
                        duty_nxt = duty_inc[N-1:0];
                    end
                end
                HOLD_HIGH: begin
                    if (hold_done) begin
                        state_nxt = FALL;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                FALL: begin
                    if (duty_q <= N'(1)) begin
                        duty_nxt  = '0;
                        state_nxt = HOLD_LOW;
                        hold_nxt  = '0;
                    end else begin
                        duty_nxt = duty_q - 1'b1;
                    end
                end
                default: begin
                    if (hold_done) begin
                        state_nxt = RISE;
                        hold_nxt  = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Envelope outputs
    always_comb begin
        phase = state;
        duty  = duty_q;
    end

    // Free-running PWM counter and registered compare, frozen while disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            pwm_out <= 1'b0;
        end else if (ena) begin
            pwm_cnt <= pwm_cnt + 1'b1;
            pwm_out <= (pwm_cnt < duty_q);
        end else begin
            pwm_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_triangle_pwm.sv
// tb/tb_triangle_pwm.sv - scoreboard bench for triangle_pwm
module tb_triangle_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic       step = 1'b0;
    logic [7:0] duty_max = 8'd3;
    logic [3:0] hold_steps = 4'd1;
    logic       pwm_out;
    logic [7:0] duty;
    logic [1:0] phase;
    logic       cycle_done;

    typedef struct packed {
        bit        cd;
        bit [7:0]  d;
        bit        cp;
        bit [1:0]  p;
        bit        cw;
        bit        w;
        bit        cc;
        bit        c;
        bit        acc;
        bit        acc_end;
        bit [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    int    acc_cnt = 0;

    triangle_pwm #(.N(8), .H(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .step       (step),
        .duty_max   (duty_max),
        .hold_steps (hold_steps),
        .pwm_out    (pwm_out),
        .duty       (duty),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    // -1 in any field means "do not check"
    function automatic exp_t ex(input int d, input int p, input int w, input int c);
        exp_t x = '0;
        if (d >= 0) begin x.cd = 1'b1; x.d = 8'(d); end
        if (p >= 0) begin x.cp = 1'b1; x.p = 2'(p); end
        if (w >= 0) begin x.cw = 1'b1; x.w = (w != 0); end
        if (c >= 0) begin x.cc = 1'b1; x.c = (c != 0); end
        return x;
    endfunction

    function automatic exp_t win(input bit last, input int cnt);
        exp_t x = '0;
        x.acc     = 1'b1;
        x.acc_end = last;
        x.cnt     = 16'(cnt);
        return x;
    endfunction

    // Drive one clock of inputs at a negedge and queue what must hold after the next posedge
    task automatic cyc(input logic r, input logic e, input logic s, input exp_t x, input string nm);
        rst  = r;
        ena  = e;
        step = s;
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(negedge clk);
    endtask

    // Monitor: one expectation is retired after every rising edge
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (x.cd) begin
                    checks++;
                    if (duty !== x.d) begin
                        errors++;
                        $display("FAIL %s duty got %0d want %0d", nm, duty, x.d);
                    end
                end
                if (x.cp) begin
                    checks++;
                    if (phase !== x.p) begin
                        errors++;
                        $display("FAIL %s phase got %0d want %0d", nm, phase, x.p);
                    end
                end
                if (x.cw) begin
                    checks++;
                    if (pwm_out !== x.w) begin
                        errors++;
                        $display("FAIL %s pwm_out got %0b want %0b", nm, pwm_out, x.w);
                    end
                end
                if (x.cc) begin
                    checks++;
                    if (cycle_done !== x.c) begin
                        errors++;
                        $display("FAIL %s cycle_done got %0b want %0b", nm, cycle_done, x.c);
                    end
                end
                if (x.acc) begin
                    if (pwm_out === 1'b1) acc_cnt++;
                    if (x.acc_end) begin
                        checks++;
                        if (acc_cnt != int'(x.cnt)) begin
                            errors++;
                            $display("FAIL %s pwm high count got %0d want %0d", nm, acc_cnt, x.cnt);
                        end
                        acc_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        int ed[10] = '{1, 2, 3, 3, 3, 2, 1, 0, 0, 0};
        int ep[10] = '{0, 0, 1, 1, 2, 2, 2, 3, 3, 0};
        @(negedge clk);

        // Reset with step/ena high
        duty_max   = 8'd3;
        hold_steps = 4'd1;
        cyc(1, 1, 1, ex(0, 0, 0, 0), "reset0");
        cyc(1, 1, 1, ex(0, 0, 0, 0), "reset1");

        // Full envelope, duty_max=3 hold_steps=1
        for (int i = 0; i < 10; i++)
            cyc(0, 1, 1, ex(ed[i], ep[i], -1, (i == 9) ? 1 : 0), $sformatf("env%0d", i + 1));
        cyc(0, 1, 0, ex(0, 0, -1, 0), "env_done_clear");

        // Reset mid-FALL at duty=2
        cyc(1, 1, 0, ex(0, 0, 0, 0), "rst_a");
        for (int i = 0; i < 6; i++)
            cyc(0, 1, 1, ex(ed[i], ep[i], -1, 0), $sformatf("fall%0d", i + 1));
        cyc(1, 1, 1, ex(0, 0, 0, 0), "rst_mid_fall");

        // Enable gating at duty=5, then live clamp
        duty_max = 8'd64;
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 1, ex(i + 1, 0, -1, 0), $sformatf("up%0d", i + 1));
        for (int i = 0; i < 8; i++)
            cyc(0, 0, (i % 2 == 0), ex(5, 0, 0, 0), $sformatf("gated%0d", i));
        cyc(0, 1, 1, ex(6, 0, -1, 0), "ena_step");
        for (int i = 0; i < 4; i++)
            cyc(0, 1, 1, ex(7 + i, 0, -1, 0), $sformatf("up_to10_%0d", i));
        duty_max = 8'd5;
        cyc(0, 1, 1, ex(5, 1, -1, 0), "live_clamp");

        // PWM accuracy at duty=64
        cyc(1, 1, 0, ex(0, 0, 0, 0), "rst_b");
        duty_max = 8'd64;
        for (int i = 0; i < 64; i++)
            cyc(0, 1, 1, ex(i + 1, (i == 63) ? 1 : 0, -1, 0), $sformatf("ramp%0d", i + 1));
        cyc(0, 1, 0, ex(64, 1, -1, -1), "settle0");
        cyc(0, 1, 0, ex(64, 1, -1, -1), "settle1");
        for (int i = 0; i < 256; i++)
            cyc(0, 1, 0, win(i == 255, 64), "pwm64");

        // PWM accuracy at duty=0
        cyc(1, 1, 0, ex(0, 0, 0, 0), "rst_c");
        cyc(0, 1, 0, ex(0, 0, 0, -1), "settle2");
        for (int i = 0; i < 256; i++)
            cyc(0, 1, 0, win(i == 255, 0), "pwm0");

        // Degenerate duty_max=0 hold_steps=0
        duty_max   = 8'd0;
        hold_steps = 4'd0;
        cyc(1, 1, 0, ex(0, 0, 0, 0), "rst_d");
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 1, ex(0, (i + 1) % 4, 0, (i % 4 == 3) ? 1 : 0), $sformatf("degen%0d", i + 1));
        cyc(0, 1, 0, ex(0, 0, 0, 0), "degen_idle");

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
